// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches over a
// req/ack handshake and buffers responses in a small FIFO in front of IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   drain_pc;
  logic [31:0]   redirect_target;
  logic          unused_low_bits;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_after;
  logic          push, pop;

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc_i[1:0];

  assign valid_o     = (count != '0);
  assign push        = (state == FETCH) && imem_ack_i && !redirect_i;
  assign pop         = valid_o && !stall_i && !redirect_i;
  assign count_after = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (imem_ack_i) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = (count_after == FULL) ? WAIT : FETCH;
        end
      end
      WAIT:  if (count < FULL) state_nxt = FETCH;
      DRAIN: if (imem_ack_i) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    // An unacked request must still complete at its old address, so it drains
    // while fetch_pc already holds the redirect target.
    if (redirect_i) begin
      fetch_pc_nxt = redirect_target;
      state_nxt    = ((state == FETCH || state == DRAIN) && !imem_ack_i) ? DRAIN : FETCH;
    end
  end

  always_comb begin
    imem_req_o  = (state == FETCH) || (state == DRAIN);
    imem_addr_o = (state == DRAIN) ? drain_pc : fetch_pc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drain_pc <= RESET_PC;
    end else if (redirect_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      if (state == FETCH && !imem_ack_i) drain_pc <= fetch_pc;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= fetch_pc;
        instr_mem[wr_ptr] <= imem_rdata_i;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_after;
    end
  end

  assign instr_o = valid_o ? instr_mem[rd_ptr] : '0;
  assign pc_o    = valid_o ? pc_mem[rd_ptr]    : '0;

endmodule
